// File: rtl/iob_fifo_sync_asym.sv
// Single-clock FIFO controller with asymmetric write/read widths. It drives an
// external two-port asymmetric RAM and owns the pointer, occupancy and flag state.
module iob_fifo_sync_asym #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10,
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
    localparam int RATIO     = MAXDATA_W / MINDATA_W,
    localparam int R_LOG     = $clog2(RATIO),
    localparam int W_ADDR_W  = (W_DATA_W > R_DATA_W) ? ADDR_W - R_LOG : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W > W_DATA_W) ? ADDR_W - R_LOG : ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                ext_mem_w_en,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
);

    localparam int LVL_W  = ADDR_W + 1;
    localparam int W_INCR = W_DATA_W / MINDATA_W;
    localparam int R_INCR = R_DATA_W / MINDATA_W;
    localparam logic [LVL_W-1:0] W_INCR_L = LVL_W'(W_INCR);
    localparam logic [LVL_W-1:0] R_INCR_L = LVL_W'(R_INCR);
    localparam logic [LVL_W-1:0] FULL_THR = LVL_W'((2 ** ADDR_W) - W_INCR);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

    logic                w_acc_s;
    logic                r_acc_s;
    logic [LVL_W-1:0]    level_nxt_s;
    logic [W_ADDR_W-1:0] w_ptr_r;
    logic [R_ADDR_W-1:0] r_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic                w_full_r;
    logic                r_empty_r;

    // Accept qualification against registered flags; nothing is accepted during reset.
    always_comb begin
        w_acc_s     = w_en & ~w_full_r & ~rst;
        r_acc_s     = r_en & ~r_empty_r & ~rst;
        level_nxt_s = level_r + (w_acc_s ? W_INCR_L : LVL_ZERO) - (r_acc_s ? R_INCR_L : LVL_ZERO);
    end

    // Pointer, occupancy and flag registers; flags follow the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_r   <= {W_ADDR_W{1'b0}};
            r_ptr_r   <= {R_ADDR_W{1'b0}};
            level_r   <= LVL_ZERO;
            w_full_r  <= 1'b0;
            r_empty_r <= 1'b1;
        end else begin
            if (w_acc_s) begin
                w_ptr_r <= w_ptr_r + W_ADDR_W'(1);
            end
            if (r_acc_s) begin
                r_ptr_r <= r_ptr_r + R_ADDR_W'(1);
            end
            level_r   <= level_nxt_s;
            w_full_r  <= (level_nxt_s > FULL_THR);
            r_empty_r <= (level_nxt_s < R_INCR_L);
        end
    end

    assign ext_mem_w_en   = w_acc_s;
    assign ext_mem_w_addr = w_ptr_r;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = r_acc_s;
    assign ext_mem_r_addr = r_ptr_r;
    assign r_data         = ext_mem_r_data;
    assign level          = level_r;
    assign w_full         = w_full_r;
    assign r_empty        = r_empty_r;

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: a 32->8 and an 8->32 instance, each with a RAM
// model, checked every cycle against byte-queue reference models.
module tb_iob_fifo_sync_asym;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: W=32, R=8, ADDR_W=10 ----------------
    logic        rst_a = 1'b1, wen_a = 1'b0, ren_a = 1'b0;
    logic [31:0] wdata_a = 32'd0;
    logic        wfull_a, rempty_a, mw_en_a, mr_en_a;
    logic [7:0]  rdata_a, mr_data_a;
    logic [10:0] level_a;
    logic [7:0]  mw_addr_a;
    logic [31:0] mw_data_a;
    logic [9:0]  mr_addr_a;
    logic [7:0]  ram_a [0:1023];

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst_a), .w_en(wen_a), .w_data(wdata_a), .w_full(wfull_a),
        .r_en(ren_a), .r_data(rdata_a), .r_empty(rempty_a), .level(level_a),
        .ext_mem_w_en(mw_en_a), .ext_mem_w_addr(mw_addr_a), .ext_mem_w_data(mw_data_a),
        .ext_mem_r_en(mr_en_a), .ext_mem_r_addr(mr_addr_a), .ext_mem_r_data(mr_data_a)
    );

    // RAM A: wide word w lands in byte slots 4w..4w+3, LSB slice lowest.
    always @(posedge clk) begin
        if (mw_en_a) begin
            for (int k = 0; k < 4; k++) ram_a[int'(mw_addr_a) * 4 + k] <= mw_data_a[8*k +: 8];
        end
        if (mr_en_a) mr_data_a <= ram_a[mr_addr_a];
    end

    // ---------------- instance B: W=8, R=32, ADDR_W=4 ----------------
    logic        rst_b = 1'b1, wen_b = 1'b0, ren_b = 1'b0;
    logic [7:0]  wdata_b = 8'd0;
    logic        wfull_b, rempty_b, mw_en_b, mr_en_b;
    logic [31:0] rdata_b, mr_data_b;
    logic [4:0]  level_b;
    logic [3:0]  mw_addr_b;
    logic [7:0]  mw_data_b;
    logic [1:0]  mr_addr_b;
    logic [7:0]  ram_b [0:15];

    iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .w_en(wen_b), .w_data(wdata_b), .w_full(wfull_b),
        .r_en(ren_b), .r_data(rdata_b), .r_empty(rempty_b), .level(level_b),
        .ext_mem_w_en(mw_en_b), .ext_mem_w_addr(mw_addr_b), .ext_mem_w_data(mw_data_b),
        .ext_mem_r_en(mr_en_b), .ext_mem_r_addr(mr_addr_b), .ext_mem_r_data(mr_data_b)
    );

    // RAM B: wide read word r gathers byte slots 4r..4r+3, lowest slot in the LSBs.
    always @(posedge clk) begin
        if (mw_en_b) ram_b[mw_addr_b] <= mw_data_b;
        if (mr_en_b) mr_data_b <= {ram_b[int'(mr_addr_b) * 4 + 3], ram_b[int'(mr_addr_b) * 4 + 2],
                                   ram_b[int'(mr_addr_b) * 4 + 1], ram_b[int'(mr_addr_b) * 4]};
    end

    // ---------------- reference models (byte queues) ----------------
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          wpa = 0, rpa = 0, wpb = 0, rpb = 0, total_wa = 0;
    logic [7:0]  exp_rd_a;
    logic [31:0] exp_rd_b;
    bit          rdv_a = 1'b0, rdv_b = 1'b0;
    bit          wacc_a, racc_a, wacc_b, racc_b;

    function automatic bit a_wok(); return qa.size() <= 1024 - 4; endfunction
    function automatic bit a_rok(); return qa.size() >= 1; endfunction
    function automatic bit b_wok(); return qb.size() <= 16 - 1; endfunction
    function automatic bit b_rok(); return qb.size() >= 4; endfunction

    initial forever begin
        @(posedge clk);
        wacc_a = wen_a && !rst_a && a_wok();
        racc_a = ren_a && !rst_a && a_rok();
        wacc_b = wen_b && !rst_b && b_wok();
        racc_b = ren_b && !rst_b && b_rok();
        if (rst_a) begin
            qa.delete(); wpa = 0; rpa = 0; rdv_a = 1'b0;
        end else begin
            if (racc_a) begin exp_rd_a = qa.pop_front(); rdv_a = 1'b1; rpa = (rpa + 1) % 1024; end
            if (wacc_a) begin
                for (int k = 0; k < 4; k++) qa.push_back(wdata_a[8*k +: 8]);
                wpa = (wpa + 1) % 256; total_wa++;
            end
        end
        if (rst_b) begin
            qb.delete(); wpb = 0; rpb = 0; rdv_b = 1'b0;
        end else begin
            if (racc_b) begin
                for (int k = 0; k < 4; k++) exp_rd_b[8*k +: 8] = qb.pop_front();
                rdv_b = 1'b1; rpb = (rpb + 1) % 4;
            end
            if (wacc_b) begin qb.push_back(wdata_b); wpb = (wpb + 1) % 16; end
        end
    end

    // Per-cycle comparison of both DUTs against the models.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("a_level", 64'(level_a), 64'(qa.size()));
            check("a_w_full", 64'(wfull_a), 64'(!a_wok()));
            check("a_r_empty", 64'(rempty_a), 64'(!a_rok()));
            check("a_mem_w_en", 64'(mw_en_a), 64'(wen_a && !rst_a && a_wok()));
            check("a_mem_r_en", 64'(mr_en_a), 64'(ren_a && !rst_a && a_rok()));
            if (wen_a && !rst_a && a_wok()) begin
                check("a_w_addr", 64'(mw_addr_a), 64'(wpa));
                check("a_w_data", 64'(mw_data_a), 64'(wdata_a));
            end
            if (ren_a && !rst_a && a_rok()) check("a_r_addr", 64'(mr_addr_a), 64'(rpa));
            if (rdv_a) check("a_r_data", 64'(rdata_a), 64'(exp_rd_a));
            check("b_level", 64'(level_b), 64'(qb.size()));
            check("b_w_full", 64'(wfull_b), 64'(!b_wok()));
            check("b_r_empty", 64'(rempty_b), 64'(!b_rok()));
            check("b_mem_w_en", 64'(mw_en_b), 64'(wen_b && !rst_b && b_wok()));
            check("b_mem_r_en", 64'(mr_en_b), 64'(ren_b && !rst_b && b_rok()));
            if (wen_b && !rst_b && b_wok()) check("b_w_addr", 64'(mw_addr_b), 64'(wpb));
            if (ren_b && !rst_b && b_rok()) check("b_r_addr", 64'(mr_addr_b), 64'(rpb));
            if (rdv_b) check("b_r_data", 64'(rdata_b), 64'(exp_rd_b));
        end
    end

    task automatic cyc_a(input bit we, input logic [31:0] wd, input bit re);
        wen_a = we; wdata_a = wd; ren_a = re;
        @(posedge clk); #1;
        wen_a = 1'b0; ren_a = 1'b0;
    endtask

    task automatic cyc_b(input bit we, input logic [7:0] wd, input bit re);
        wen_b = we; wdata_b = wd; ren_b = re;
        @(posedge clk); #1;
        wen_b = 1'b0; ren_b = 1'b0;
    endtask

    // Directed scenarios, then randomized streaming.
    initial begin
        int n;
        int start_wa;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 64'(level_a), 64'd0);
        check("rst_r_empty", 64'(rempty_a), 64'd1);
        check("rst_w_full", 64'(wfull_a), 64'd0);
        check("rst_mem_w_en", 64'(mw_en_a), 64'd0);
        check("rst_mem_r_en", 64'(mr_en_a), 64'd0);
        check("rst_b_r_empty", 64'(rempty_b), 64'd1);
        rst_a = 1'b0; rst_b = 1'b0; model_on = 1'b1;

        // width split
        cyc_a(1'b1, 32'h44332211, 1'b0);
        check("split_level", 64'(level_a), 64'd4);
        check("split_r_empty", 64'(rempty_a), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc_a(1'b0, 32'd0, 1'b1);
            check("split_r_data", 64'(rdata_a), 64'(8'h11 * (k + 1)));
        end
        check("split_level_end", 64'(level_a), 64'd0);
        check("split_r_empty_end", 64'(rempty_a), 64'd1);

        // fill and overflow
        for (int i = 0; i < 256; i++) cyc_a(1'b1, 32'(i + 10), 1'b0);
        check("fill_w_full", 64'(wfull_a), 64'd1);
        check("fill_level", 64'(level_a), 64'd1024);
        wen_a = 1'b1; wdata_a = 32'hDEADBEEF; #1;
        check("ovf_mem_w_en", 64'(mw_en_a), 64'd0);
        @(posedge clk); #1; wen_a = 1'b0;
        check("ovf_level", 64'(level_a), 64'd1024);
        ren_a = 1'b1;
        repeat (1024) @(posedge clk);
        #1; ren_a = 1'b0;
        check("drain_level", 64'(level_a), 64'd0);
        ren_a = 1'b1; #1;
        check("empty_mem_r_en", 64'(mr_en_a), 64'd0);
        @(posedge clk); #1; ren_a = 1'b0;

        // simultaneous ops
        cyc_a(1'b1, $urandom, 1'b0);
        cyc_a(1'b1, $urandom, 1'b0);
        check("simul_pre_level", 64'(level_a), 64'd8);
        cyc_a(1'b1, $urandom, 1'b1);
        check("simul_level", 64'(level_a), 64'd11);
        ren_a = 1'b1;
        repeat (11) @(posedge clk);
        #1; ren_a = 1'b0;
        check("simul_drain", 64'(level_a), 64'd0);

        // wrap-around streaming
        start_wa = total_wa; n = 0;
        while ((total_wa - start_wa) < 600 && n < 20000) begin
            wen_a = ($urandom_range(0, 3) != 0); wdata_a = $urandom;
            ren_a = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1; n++;
        end
        wen_a = 1'b0; ren_a = 1'b1; n = 0;
        while (qa.size() > 0 && n < 2000) begin @(posedge clk); #1; n++; end
        ren_a = 1'b0;
        check("wrap_writes", 64'(total_wa - start_wa >= 600), 64'd1);
        check("wrap_drained", 64'(level_a), 64'd0);

        // reverse asymmetry
        cyc_b(1'b1, 8'h11, 1'b0); check("rev_empty1", 64'(rempty_b), 64'd1);
        cyc_b(1'b1, 8'h22, 1'b0); check("rev_empty2", 64'(rempty_b), 64'd1);
        cyc_b(1'b1, 8'h33, 1'b0); check("rev_empty3", 64'(rempty_b), 64'd1);
        cyc_b(1'b1, 8'h44, 1'b0); check("rev_empty4", 64'(rempty_b), 64'd0);
        check("rev_level", 64'(level_b), 64'd4);
        cyc_b(1'b0, 8'd0, 1'b1);
        check("rev_r_data", 64'(rdata_b), 64'h44332211);
        for (int k = 0; k < 6; k++) cyc_b(1'b1, 8'(k), 1'b0);
        rst_b = 1'b1; ren_b = 1'b1; #1;
        check("rev_rst_mem_r_en", 64'(mr_en_b), 64'd0);
        @(posedge clk); #1; rst_b = 1'b0; ren_b = 1'b0;
        check("rev_rst_level", 64'(level_b), 64'd0);
        check("rev_rst_r_empty", 64'(rempty_b), 64'd1);
        for (int i = 0; i < 400; i++) begin
            wen_b = ($urandom_range(0, 1) != 0); wdata_b = 8'($urandom);
            ren_b = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        wen_b = 1'b0; ren_b = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_fifo_sync_asym.md
# iob_fifo_sync_asym

Single-clock FIFO controller with asymmetric write and read widths. Drives an external iob_ram_t2p_asym instance through its write and read ports, with both RAM clocks tied to `clk`. It sits directly upstream of that RAM and owns all pointer, occupancy and flag logic. The RAM stores the data.

## Interface
- `W_DATA_W`, 32, write word width.
- `R_DATA_W`, 8, read word width.
- `ADDR_W`, 10, address width in min-width units; capacity = 2**ADDR_W min-width words. Same meaning as the RAM's `ADDR_W`.
- Derived values:
  - MAXDATA_W/MINDATA_W = max/min of the two widths. RATIO = MAXDATA_W/MINDATA_W, a power of two; ADDR_W >= log2(RATIO).
  - W_ADDR_W/R_ADDR_W = ADDR_W for the narrow side, ADDR_W-log2(RATIO) for the wide side.
  - W_INCR = W_DATA_W/MINDATA_W; R_INCR = R_DATA_W/MINDATA_W.
- Ports:
  - `clk` in 1: single clock for all logic; also drives both RAM clocks.
  - `rst` in 1: synchronous, active-high reset.
  - `w_en` in 1: write request.
  - `w_data` in W_DATA_W: write word.
  - `w_full` out 1: no room for one more write word.
  - `r_en` in 1: read request.
  - `r_data` out R_DATA_W: read word, direct from `ext_mem_r_data`.
  - `r_empty` out 1: less than one full read word stored.
  - `level` out ADDR_W+1: occupancy in min-width units.
  - `ext_mem_w_en` out 1: RAM write enable.
  - `ext_mem_w_addr` out W_ADDR_W: RAM write address.
  - `ext_mem_w_data` out W_DATA_W: RAM write data.
  - `ext_mem_r_en` out 1: RAM read enable.
  - `ext_mem_r_addr` out R_ADDR_W: RAM read address.
  - `ext_mem_r_data` in R_DATA_W: RAM registered read data.

## Operation
- **Accept rules:**
  - A write is accepted when `w_en & ~w_full`.
  - A read is accepted when `r_en & ~r_empty`.
  - A request that is not accepted is ignored: no pointer change, no level change, no RAM enable.
- **RAM drive:**
  - `ext_mem_w_en` = write accepted; `ext_mem_w_addr` = write pointer; `ext_mem_w_data` = `w_data`. All combinational.
  - `ext_mem_r_en` = read accepted; `ext_mem_r_addr` = read pointer. All combinational.
- **Pointers:**
  - Write pointer is W_ADDR_W bits; read pointer is R_ADDR_W bits.
  - Each advances by 1 per accepted op and wraps modulo 2**width with no special case.
- **Level:**
  - Accepted write adds W_INCR; accepted read subtracts R_INCR.
  - Simultaneous accepted write and read update by W_INCR-R_INCR in the same cycle.
  - Level never exceeds 2**ADDR_W and never goes below 0.
- **Flags, registered and derived from next-level:**
  - `w_full` = level > 2**ADDR_W - W_INCR.
  - `r_empty` = level < R_INCR.
- **Byte order:** lowest min-width slice is first in, first out.
  - W>R: a write word is read back LSB slice first.
  - W<R: the first write fills the read word's LSBs.
- **Reset:**
  - Synchronous. Pointers and level go to 0, `w_full`=0, `r_empty`=1, all `ext_mem_*` enables 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data; a read issued in the reset cycle is not accepted.
  - `r_data` has no reset value; it is undefined until the first accepted read.

## Timing
- Flags and `level` update one cycle after the accepted op's clock edge.
- A write at edge N is readable from edge N+1. This holds when `r_empty` deasserts and the RAM write/read ordering is met: read address differs from write address once `level` counts the data.
- Read latency is 1: `r_data` is valid after the edge following the accepted `r_en`.
- `r_data` holds its value while no read is accepted, because the RAM read enable is low.
- Back-to-back reads/writes at full rate are supported every cycle.
- Write at full with a simultaneous accepted read is still rejected, because `w_full` is evaluated on the registered state.

## Test plan
- **Reset state:** assert `rst` 2 cycles -> `level`=0, `r_empty`=1, `w_full`=0, `ext_mem_w_en`=`ext_mem_r_en`=0.
- **Width split (W=32, R=8):** write 0x44332211 -> `level`=4, `r_empty`=0 next cycle. Four reads -> `r_data` 0x11, 0x22, 0x33, 0x44, each one cycle after `r_en`. Afterwards `level`=0, `r_empty`=1.
- **Fill and overflow (W=32, R=8, ADDR_W=10):**
  - Write 256 words i+10 -> `w_full`=1 after the 256th, `level`=1024.
  - A 257th `w_en` -> no `ext_mem_w_en`, `level` stays 1024.
  - A read while empty after drain -> no `ext_mem_r_en`.
- **Simultaneous ops:** with `level`=8, assert `w_en` and `r_en` together -> `level`=11 next cycle; data order preserved.
- **Wrap-around:** stream 600 write words, reading continuously -> pointers wrap ≥2 times; every byte matches the expected LSB-first sequence; no flag glitch.
- **Reverse asymmetry (W=8, R=32):**
  - Write 0x11, 0x22, 0x33 -> `r_empty` stays 1.
  - The 4th write 0x44 -> `r_empty`=0; read returns 0x44332211.
  - Assert `rst` mid-stream -> `level`=0 and `r_empty`=1 next cycle.
